// File: rtl/sva_pkg.sv
// rtl/sva_pkg.sv - shared types for the sequence thread engine
package sva_pkg;

    localparam int STEP_W  = 4;
    localparam int START_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_LAUNCH = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic               active;
        logic [STEP_W-1:0]  step;
        logic [START_W-1:0] start_period;
    } slot_t;

endpackage

// File: rtl/sva_edge_sync.sv
// rtl/sva_edge_sync.sv - three-stage gclk synchroniser with rising-edge detect
module sva_edge_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic gclk,
    output logic rise
);

    logic d0, d1, d2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d0 <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else if (clr) begin
            d0 <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d0 <= gclk;
            d1 <= d0;
            d2 <= d1;
        end
    end

    assign rise = d1 & ~d2 & ~clr;

endmodule

// File: rtl/sva_thread_engine.sv
// rtl/sva_thread_engine.sv - multi-slot sequence checker stepped once per gclk period
module sva_thread_engine
    import sva_pkg::*;
#(
    parameter int NUM_SIG     = 2,
    parameter int SEQ_LEN     = 3,
    parameter int MAX_THREADS = 4,
    parameter logic [SEQ_LEN-1:0][NUM_SIG-1:0] STEP_MASK = '0,
    parameter logic [SEQ_LEN-1:0][NUM_SIG-1:0] STEP_VAL  = '0,
    parameter bit FAIL_ON_FIRST = 1'b1,
    parameter int TIMER_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst_n,
    input  logic                             gclk,
    input  logic                             grst,
    input  logic                             en,
    input  logic [NUM_SIG-1:0]               sig_in,
    output logic                             busy,
    output logic                             succ,
    output logic                             fail,
    output logic [TIMER_WIDTH-1:0]           fail_start,
    output logic                             overflow,
    output logic                             miss,
    output logic [CNT_WIDTH-1:0]             pass_cnt,
    output logic [CNT_WIDTH-1:0]             fail_cnt,
    output logic [$clog2(MAX_THREADS+1)-1:0] active_cnt
);

    localparam int IDX_W = (MAX_THREADS > 1) ? $clog2(MAX_THREADS) : 1;
    localparam int ACT_W = $clog2(MAX_THREADS+1);

    ctrl_state_t            state_q, state_d;
    slot_t                  slots_q [MAX_THREADS];
    slot_t                  slots_d [MAX_THREADS];
    slot_t                  cur;
    logic [NUM_SIG-1:0]     sample_q, sample_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d, launch_period;
    logic [IDX_W-1:0]       idx_q, idx_d, free_idx;
    logic                   free_found;
    logic                   succ_d, fail_d, overflow_d, miss_d;
    logic [TIMER_WIDTH-1:0] fail_start_d;
    logic [CNT_WIDTH-1:0]   pass_d, fail_cnt_d;
    logic                   rise;

    sva_edge_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (grst),
        .gclk      (gclk),
        .rise      (rise)
    );

    function automatic logic step_match(input logic [NUM_SIG-1:0] s, input logic [STEP_W-1:0] k);
        step_match = 1'b0;
        for (int j = 0; j < SEQ_LEN; j++)
            if (k == STEP_W'(j))
                step_match = ((s ^ STEP_VAL[j]) & STEP_MASK[j]) == '0;
    endfunction

    always_comb begin
        state_d      = state_q;
        slots_d      = slots_q;
        sample_d     = sample_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        succ_d       = 1'b0;
        fail_d       = 1'b0;
        fail_start_d = '0;
        overflow_d   = 1'b0;
        free_found   = 1'b0;
        free_idx     = '0;
        cur          = slots_q[idx_q];
        // timer already advanced at this period's rise, so the period index is one behind
        launch_period = timer_q - 1'b1;
        miss_d       = rise & (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d  = ST_SCAN;
                    sample_d = sig_in;
                    timer_d  = timer_q + 1'b1;
                    idx_d    = '0;
                end
            end
            ST_SCAN: begin
                if (cur.active) begin
                    if (step_match(sample_q, cur.step)) begin
                        if (cur.step == STEP_W'(SEQ_LEN-1)) begin
                            succ_d = 1'b1;
                            slots_d[idx_q].active = 1'b0;
                        end else begin
                            slots_d[idx_q].step = cur.step + 1'b1;
                        end
                    end else begin
                        fail_d       = 1'b1;
                        fail_start_d = cur.start_period[TIMER_WIDTH-1:0];
                        slots_d[idx_q].active = 1'b0;
                    end
                end
                if (idx_q == IDX_W'(MAX_THREADS-1)) state_d = ST_LAUNCH;
                else                                 idx_d   = idx_q + 1'b1;
            end
            ST_LAUNCH: begin
                state_d = ST_IDLE;
                if (en) begin
                    if (step_match(sample_q, '0)) begin
                        if (SEQ_LEN == 1) begin
                            succ_d = 1'b1;
                        end else begin
                            for (int i = MAX_THREADS-1; i >= 0; i--) begin
                                if (!slots_q[i].active) begin
                                    free_found = 1'b1;
                                    free_idx   = IDX_W'(i);
                                end
                            end
                            if (free_found)
                                slots_d[free_idx] = '{active: 1'b1, step: STEP_W'(1),
                                                      start_period: START_W'(launch_period)};
                            else
                                overflow_d = 1'b1;
                        end
                    end else if (FAIL_ON_FIRST) begin
                        fail_d       = 1'b1;
                        fail_start_d = launch_period;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pass_d     = pass_cnt;
        fail_cnt_d = fail_cnt;
        if (succ_d && (pass_cnt != '1)) pass_d     = pass_cnt + 1'b1;
        if (fail_d && (fail_cnt != '1)) fail_cnt_d = fail_cnt + 1'b1;

        if (grst) begin
            state_d      = ST_IDLE;
            for (int i = 0; i < MAX_THREADS; i++) slots_d[i] = '0;
            sample_d     = '0;
            timer_d      = '0;
            idx_d        = '0;
            succ_d       = 1'b0;
            fail_d       = 1'b0;
            fail_start_d = '0;
            overflow_d   = 1'b0;
            miss_d       = 1'b0;
            pass_d       = '0;
            fail_cnt_d   = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < MAX_THREADS; i++) slots_q[i] <= '0;
            sample_q   <= '0;
            timer_q    <= '0;
            idx_q      <= '0;
            succ       <= 1'b0;
            fail       <= 1'b0;
            fail_start <= '0;
            overflow   <= 1'b0;
            miss       <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            slots_q    <= slots_d;
            sample_q   <= sample_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            succ       <= succ_d;
            fail       <= fail_d;
            fail_start <= fail_start_d;
            overflow   <= overflow_d;
            miss       <= miss_d;
            pass_cnt   <= pass_d;
            fail_cnt   <= fail_cnt_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < MAX_THREADS; i++)
            active_cnt = active_cnt + ACT_W'(slots_q[i].active);
    end

endmodule

// File: tb/tb_sva_thread_engine.sv
// tb/tb_sva_thread_engine.sv - directed bench for the sequence thread engine
module tb_sva_thread_engine;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n, gclk, grst, en;
    logic [1:0]  sig_in;

    logic        busy, succ, fail, overflow, miss;
    logic [7:0]  fail_start;
    logic [15:0] pass_cnt, fail_cnt;
    logic [2:0]  active_cnt;

    logic        busy1, succ1, fail1, ovf1, miss1;
    logic [7:0]  fail_start1;
    logic [15:0] pass_cnt1, fail_cnt1;
    logic [0:0]  active_cnt1;

    int total = 0;
    int bad   = 0;
    int n_succ, n_fail, n_ovf, n_ovf1, n_miss, n_busy;
    int first_fs, last_fs;
    bit got_fs;

    always #5 sys_clk = ~sys_clk;

    sva_thread_engine #(
        .NUM_SIG(2), .SEQ_LEN(3), .MAX_THREADS(4),
        .STEP_MASK(6'b01_10_01), .STEP_VAL(6'b00_10_01),
        .FAIL_ON_FIRST(1'b1), .TIMER_WIDTH(8), .CNT_WIDTH(16)
    ) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .gclk(gclk), .grst(grst),
        .en(en), .sig_in(sig_in), .busy(busy), .succ(succ), .fail(fail),
        .fail_start(fail_start), .overflow(overflow), .miss(miss),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .active_cnt(active_cnt)
    );

    sva_thread_engine #(
        .NUM_SIG(2), .SEQ_LEN(3), .MAX_THREADS(1),
        .STEP_MASK(6'b01_10_01), .STEP_VAL(6'b00_10_01),
        .FAIL_ON_FIRST(1'b1), .TIMER_WIDTH(8), .CNT_WIDTH(16)
    ) u_one (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .gclk(gclk), .grst(grst),
        .en(en), .sig_in(sig_in), .busy(busy1), .succ(succ1), .fail(fail1),
        .fail_start(fail_start1), .overflow(ovf1), .miss(miss1),
        .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1), .active_cnt(active_cnt1)
    );

    always @(negedge sys_clk) begin
        if (succ) n_succ++;
        if (fail) begin
            n_fail++;
            if (!got_fs) first_fs = int'(fail_start);
            got_fs  = 1'b1;
            last_fs = int'(fail_start);
        end
        if (overflow) n_ovf++;
        if (ovf1)     n_ovf1++;
        if (miss)     n_miss++;
        if (busy)     n_busy++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge sys_clk);
        n_succ = 0; n_fail = 0; n_ovf = 0; n_ovf1 = 0; n_miss = 0; n_busy = 0;
        first_fs = -1; last_fs = -1; got_fs = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0; gclk = 1'b0; grst = 1'b0; en = 1'b0; sig_in = 2'b00;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic run_period(input logic [1:0] s, input logic e, input int half);
        @(negedge sys_clk);
        sig_in = s; en = e; gclk = 1'b1;
        repeat (half) @(negedge sys_clk);
        gclk = 1'b0;
        repeat (half - 1) @(negedge sys_clk);
    endtask

    task automatic wait_busy(input string tag);
        int w = 0;
        while (!busy && w < 10) begin
            @(negedge sys_clk);
            w++;
        end
        chk(tag, 32'(busy), 32'd1);
    endtask

    initial begin
        sys_rst_n = 1'b0; gclk = 1'b0; grst = 1'b0; en = 1'b0; sig_in = 2'b00;
        do_reset();
        chk("rst_busy",   32'(busy), 0);
        chk("rst_active", 32'(active_cnt), 0);
        chk("rst_pass",   32'(pass_cnt), 0);
        chk("rst_failc",  32'(fail_cnt), 0);
        chk("rst_pulses", 32'({succ, fail, overflow, miss}), 0);

        // pass path: 01, 10, 00 with a single launch
        clr_mon(); run_period(2'b01, 1'b1, 10);
        chk("p34_p0_active", 32'(active_cnt), 1);
        chk("p34_p0_busylen", 32'(n_busy), 5);
        chk("p34_p0_succ", 32'(n_succ), 0);
        clr_mon(); run_period(2'b10, 1'b0, 10);
        chk("p34_p1_active", 32'(active_cnt), 1);
        chk("p34_p1_events", 32'(n_succ + n_fail), 0);
        clr_mon(); run_period(2'b00, 1'b0, 10);
        chk("p34_p2_succ", 32'(n_succ), 1);
        chk("p34_p2_fail", 32'(n_fail), 0);
        chk("p34_pass_cnt", 32'(pass_cnt), 1);
        chk("p34_fail_cnt", 32'(fail_cnt), 0);
        chk("p34_active", 32'(active_cnt), 0);

        // step-1 mismatch plus a failing launch in the same period
        do_reset();
        clr_mon(); run_period(2'b01, 1'b1, 10);
        clr_mon(); run_period(2'b00, 1'b1, 10);
        chk("p35_nfail", 32'(n_fail), 2);
        chk("p35_first_fs", 32'(first_fs), 0);
        chk("p35_launch_fs", 32'(last_fs), 1);
        chk("p35_fail_cnt", 32'(fail_cnt), 2);
        chk("p35_active", 32'(active_cnt), 0);

        // steady 11: every attempt dies at step 2; single-slot copy overflows every other period
        do_reset();
        for (int p = 0; p < 5; p++) begin
            clr_mon(); run_period(2'b11, 1'b1, 10);
            chk($sformatf("p36_active_p%0d", p), 32'(active_cnt), (p == 0) ? 1 : 2);
            chk($sformatf("p36_ovf_p%0d", p), 32'(n_ovf), 0);
            chk($sformatf("p36_nfail_p%0d", p), 32'(n_fail), (p >= 2) ? 1 : 0);
            if (p >= 2) chk($sformatf("p36_fs_p%0d", p), 32'(last_fs), 32'(p - 2));
            chk($sformatf("p37_ovf1_p%0d", p), 32'(n_ovf1), 32'(p % 2));
        end
        chk("p36_fail_cnt", 32'(fail_cnt), 3);
        chk("p37_fail_cnt1", 32'(fail_cnt1), 2);

        // fast gclk: every other edge lands while busy
        do_reset();
        clr_mon();
        for (int k = 0; k < 8; k++) run_period(2'b00, 1'b1, 2);
        repeat (12) @(negedge sys_clk);
        chk("p38_miss", 32'(n_miss), 4);
        chk("p38_nfail", 32'(n_fail), 4);
        chk("p38_first_fs", 32'(first_fs), 0);
        chk("p38_last_fs", 32'(last_fs), 3);
        chk("p38_fail_cnt", 32'(fail_cnt), 4);

        // soft clear in the middle of a scan
        do_reset();
        for (int p = 0; p < 3; p++) run_period(2'b11, 1'b1, 10);
        chk("p39g_pre_active", 32'(active_cnt), 2);
        chk("p39g_pre_failc", 32'(fail_cnt), 1);
        @(negedge sys_clk); sig_in = 2'b11; gclk = 1'b1;
        wait_busy("p39g_busy_seen");
        @(negedge sys_clk); grst = 1'b1;
        clr_mon();
        @(negedge sys_clk);
        chk("p39g_busy", 32'(busy), 0);
        chk("p39g_active", 32'(active_cnt), 0);
        chk("p39g_cnts", 32'({pass_cnt, fail_cnt}), 0);
        gclk = 1'b0;
        repeat (2) @(negedge sys_clk);
        grst = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("p39g_no_events", 32'(n_succ + n_fail), 0);
        chk("p39g_post_active", 32'(active_cnt), 0);

        // hard reset in the middle of a scan
        do_reset();
        for (int p = 0; p < 3; p++) run_period(2'b11, 1'b1, 10);
        chk("p39r_pre_failc", 32'(fail_cnt), 1);
        @(negedge sys_clk); sig_in = 2'b11; gclk = 1'b1;
        wait_busy("p39r_busy_seen");
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("p39r_busy", 32'(busy), 0);
        chk("p39r_active", 32'(active_cnt), 0);
        chk("p39r_cnts", 32'({pass_cnt, fail_cnt}), 0);
        chk("p39r_pulses", 32'({succ, fail}), 0);
        gclk = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clr_mon();
        repeat (20) @(negedge sys_clk);
        chk("p39r_no_events", 32'(n_succ + n_fail), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
